// File: rtl/bus_arbiter.sv
// Shares one single-outstanding request/response bus between the fetch and data
// ports of a core. Data has priority; completed accesses are remembered until the pipeline advances.
module bus_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        longest_stall,

    input  logic        inst_en,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_stall,

    input  logic        data_en,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_stall,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        D_ADDR,
        D_DATA,
        I_ADDR,
        I_DATA
    } state_t;

    state_t state;
    logic   inst_done;
    logic   data_done;
    logic   inst_pend;
    logic   data_pend;

    assign inst_pend  = inst_en & ~inst_done;
    assign data_pend  = data_en & ~data_done;
    assign inst_stall = inst_pend;
    assign data_stall = data_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bus_req    <= 1'b0;
            bus_wr     <= 1'b0;
            bus_wstrb  <= 4'b0;
            bus_addr   <= 32'b0;
            bus_wdata  <= 32'b0;
            inst_rdata <= 32'b0;
            data_rdata <= 32'b0;
            inst_done  <= 1'b0;
            data_done  <= 1'b0;
        end else begin
            // NOTE: with non-blocking assignments the last one in the block wins, so a
            // completion below overrides this clear when both happen on the same edge.
            if (!longest_stall) begin
                inst_done <= 1'b0;
                data_done <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (data_pend) begin
                        state     <= D_ADDR;
                        bus_req   <= 1'b1;
                        bus_addr  <= data_addr;
                        bus_wr    <= |data_wen;
                        bus_wstrb <= data_wen;
                        bus_wdata <= data_wdata;
                    end else if (inst_pend) begin
                        state     <= I_ADDR;
                        bus_req   <= 1'b1;
                        bus_addr  <= inst_addr;
                        bus_wr    <= 1'b0;
                        bus_wstrb <= 4'b0;
                        bus_wdata <= 32'b0;
                    end
                end
                D_ADDR: begin
                    if (bus_addr_ok) begin
                        state   <= D_DATA;
                        bus_req <= 1'b0;
                    end
                end
                I_ADDR: begin
                    if (bus_addr_ok) begin
                        state   <= I_DATA;
                        bus_req <= 1'b0;
                    end
                end
                D_DATA: begin
                    if (bus_data_ok) begin
                        state     <= IDLE;
                        data_done <= 1'b1;
                        // Stores complete without disturbing the last loaded word.
                        if (!bus_wr) begin
                            data_rdata <= bus_rdata;
                        end
                    end
                end
                I_DATA: begin
                    if (bus_data_ok) begin
                        state      <= IDLE;
                        inst_done  <= 1'b1;
                        inst_rdata <= bus_rdata;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed protocol scenarios plus a randomized run checked
// against a transaction-level model of the arbitration rules.
module tb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        longest_stall;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_stall;
    logic        data_en;
    logic [31:0] data_addr;
    logic [3:0]  data_wen;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_stall;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int n_vec = 0;
    int n_err = 0;

    bus_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .longest_stall (longest_stall),
        .inst_en       (inst_en),
        .inst_addr     (inst_addr),
        .inst_rdata    (inst_rdata),
        .inst_stall    (inst_stall),
        .data_en       (data_en),
        .data_addr     (data_addr),
        .data_wen      (data_wen),
        .data_wdata    (data_wdata),
        .data_rdata    (data_rdata),
        .data_stall    (data_stall),
        .bus_req       (bus_req),
        .bus_wr        (bus_wr),
        .bus_wstrb     (bus_wstrb),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_addr_ok   (bus_addr_ok),
        .bus_data_ok   (bus_data_ok),
        .bus_rdata     (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        longest_stall = 1'b0;
        inst_en       = 1'b0;
        inst_addr     = 32'h0;
        data_en       = 1'b0;
        data_addr     = 32'h0;
        data_wen      = 4'h0;
        data_wdata    = 32'h0;
        bus_addr_ok   = 1'b0;
        bus_data_ok   = 1'b0;
        bus_rdata     = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    // Let the pipeline advance once with no requests so done flags clear.
    task automatic release_core();
        longest_stall = 1'b0;
        inst_en       = 1'b0;
        data_en       = 1'b0;
        data_wen      = 4'h0;
        tick();
    endtask

    // Acts as the bus slave for one transaction: waits (bounded) for bus_req, records
    // the request fields, accepts after addr_wait cycles, then responds next cycle.
    task automatic serve(input logic [31:0] rdata, input int addr_wait, output logic ok,
                         output logic [31:0] a, output logic w, output logic [3:0] s,
                         output logic [31:0] d);
        ok = 1'b0;
        a  = 32'h0;
        w  = 1'b0;
        s  = 4'h0;
        d  = 32'h0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus_req) ok = 1'b1;
            else tick();
        end
        if (ok) begin
            a = bus_addr;
            w = bus_wr;
            s = bus_wstrb;
            d = bus_wdata;
            repeat (addr_wait) tick();
            bus_addr_ok = 1'b1;
            tick();
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b1;
            bus_rdata   = rdata;
            tick();
            bus_data_ok = 1'b0;
            bus_rdata   = $urandom;
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        idle_inputs();
        inst_en = 1'b1;
        #2;
        n_vec++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL reset_bus_req: got %0h want 0", bus_req); end
        n_vec++; if (bus_wr !== 1'b0) begin n_err++; $display("FAIL reset_bus_wr: got %0h want 0", bus_wr); end
        n_vec++; if (bus_wstrb !== 4'h0) begin n_err++; $display("FAIL reset_bus_wstrb: got %0h want 0", bus_wstrb); end
        n_vec++; if (bus_addr !== 32'h0) begin n_err++; $display("FAIL reset_bus_addr: got %08h want 0", bus_addr); end
        n_vec++; if (bus_wdata !== 32'h0) begin n_err++; $display("FAIL reset_bus_wdata: got %08h want 0", bus_wdata); end
        n_vec++; if (inst_rdata !== 32'h0) begin n_err++; $display("FAIL reset_inst_rdata: got %08h want 0", inst_rdata); end
        n_vec++; if (data_rdata !== 32'h0) begin n_err++; $display("FAIL reset_data_rdata: got %08h want 0", data_rdata); end
        n_vec++; if (inst_stall !== 1'b1) begin n_err++; $display("FAIL reset_inst_stall: got %0h want 1", inst_stall); end
        n_vec++; if (data_stall !== 1'b0) begin n_err++; $display("FAIL reset_data_stall: got %0h want 0", data_stall); end
        do_reset();
    endtask

    task automatic test_fetch();
        longest_stall = 1'b1;
        inst_en       = 1'b1;
        inst_addr     = 32'hBFC00000;
        #1;
        n_vec++; if (inst_stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall0: got %0h want 1", inst_stall); end
        tick();
        n_vec++; if (bus_req !== 1'b1) begin n_err++; $display("FAIL fetch_req: got %0h want 1", bus_req); end
        n_vec++; if (bus_addr !== 32'hBFC00000) begin n_err++; $display("FAIL fetch_addr: got %08h want bfc00000", bus_addr); end
        n_vec++; if (bus_wr !== 1'b0) begin n_err++; $display("FAIL fetch_wr: got %0h want 0", bus_wr); end
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        n_vec++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL fetch_req_drop: got %0h want 0", bus_req); end
        n_vec++; if (inst_stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall2: got %0h want 1", inst_stall); end
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h3C1D8000;
        tick();
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
        n_vec++; if (inst_stall !== 1'b0) begin n_err++; $display("FAIL fetch_stall3: got %0h want 0", inst_stall); end
        n_vec++; if (inst_rdata !== 32'h3C1D8000) begin n_err++; $display("FAIL fetch_rdata: got %08h want 3c1d8000", inst_rdata); end
        repeat (2) begin
            tick();
            n_vec++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL fetch_no_reissue: got %0h want 0", bus_req); end
        end
        release_core();
    endtask

    task automatic test_both();
        logic        ok;
        logic [31:0] a;
        logic        w;
        logic [3:0]  s;
        logic [31:0] d;
        longest_stall = 1'b1;
        data_en       = 1'b1;
        data_addr     = 32'h80001000;
        data_wen      = 4'h0;
        inst_en       = 1'b1;
        inst_addr     = 32'hBFC00004;
        serve(32'h11112222, 0, ok, a, w, s, d);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL both_data_timeout: got %0h want 1", ok); end
        n_vec++; if (a !== 32'h80001000) begin n_err++; $display("FAIL both_first_addr: got %08h want 80001000", a); end
        n_vec++; if (w !== 1'b0) begin n_err++; $display("FAIL both_first_wr: got %0h want 0", w); end
        n_vec++; if (data_stall !== 1'b0) begin n_err++; $display("FAIL both_data_stall: got %0h want 0", data_stall); end
        n_vec++; if (inst_stall !== 1'b1) begin n_err++; $display("FAIL both_inst_stall: got %0h want 1", inst_stall); end
        n_vec++; if (data_rdata !== 32'h11112222) begin n_err++; $display("FAIL both_data_rdata: got %08h want 11112222", data_rdata); end
        tick();
        n_vec++; if (bus_req !== 1'b1) begin n_err++; $display("FAIL both_inst_req_next: got %0h want 1", bus_req); end
        n_vec++; if (bus_addr !== 32'hBFC00004) begin n_err++; $display("FAIL both_second_addr: got %08h want bfc00004", bus_addr); end
        serve(32'h33334444, 0, ok, a, w, s, d);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL both_inst_timeout: got %0h want 1", ok); end
        n_vec++; if (inst_stall !== 1'b0) begin n_err++; $display("FAIL both_inst_done: got %0h want 0", inst_stall); end
        n_vec++; if (inst_rdata !== 32'h33334444) begin n_err++; $display("FAIL both_inst_rdata: got %08h want 33334444", inst_rdata); end
        tick();
        n_vec++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL both_no_reissue: got %0h want 0", bus_req); end
        release_core();
    endtask

    task automatic test_store();
        logic        ok;
        logic [31:0] a;
        logic        w;
        logic [3:0]  s;
        logic [31:0] d;
        longest_stall = 1'b1;
        data_en       = 1'b1;
        data_addr     = 32'h80002000;
        data_wen      = 4'b0011;
        data_wdata    = 32'h0000ABCD;
        serve(32'hDEADBEEF, 0, ok, a, w, s, d);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL store_timeout: got %0h want 1", ok); end
        n_vec++; if (w !== 1'b1) begin n_err++; $display("FAIL store_wr: got %0h want 1", w); end
        n_vec++; if (s !== 4'b0011) begin n_err++; $display("FAIL store_wstrb: got %0h want 3", s); end
        n_vec++; if (d !== 32'h0000ABCD) begin n_err++; $display("FAIL store_wdata: got %08h want 0000abcd", d); end
        n_vec++; if (data_rdata !== 32'h11112222) begin n_err++; $display("FAIL store_rdata_kept: got %08h want 11112222", data_rdata); end
        n_vec++; if (data_stall !== 1'b0) begin n_err++; $display("FAIL store_stall: got %0h want 0", data_stall); end
        release_core();
    endtask

    task automatic test_freeze();
        logic        ok;
        logic [31:0] a;
        logic        w;
        logic [3:0]  s;
        logic [31:0] d;
        longest_stall = 1'b1;
        data_en       = 1'b1;
        data_addr     = 32'h80003000;
        data_wen      = 4'h0;
        serve(32'h55556666, 0, ok, a, w, s, d);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL freeze_timeout1: got %0h want 1", ok); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if ({bus_req, data_stall} !== 2'b00) begin n_err++; $display("FAIL freeze_hold: cycle %0d req/stall got %b want 00", i, {bus_req, data_stall}); end
        end
        longest_stall = 1'b0;
        tick();
        longest_stall = 1'b1;
        n_vec++; if (data_stall !== 1'b1) begin n_err++; $display("FAIL freeze_clear: got %0h want 1", data_stall); end
        n_vec++; if (data_rdata !== 32'h55556666) begin n_err++; $display("FAIL freeze_rdata_kept: got %08h want 55556666", data_rdata); end
        serve(32'h77778888, 0, ok, a, w, s, d);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL freeze_reissue: got %0h want 1", ok); end
        n_vec++; if (a !== 32'h80003000) begin n_err++; $display("FAIL freeze_reissue_addr: got %08h want 80003000", a); end
        n_vec++; if (data_rdata !== 32'h77778888) begin n_err++; $display("FAIL freeze_rdata2: got %08h want 77778888", data_rdata); end
        release_core();
    endtask

    task automatic test_backpressure();
        longest_stall = 1'b1;
        inst_en       = 1'b1;
        inst_addr     = 32'h00400000;
        tick();
        for (int i = 0; i < 4; i++) begin
            inst_addr = $urandom;
            #1;
            n_vec++; if ({bus_req, bus_addr} !== {1'b1, 32'h00400000}) begin n_err++; $display("FAIL bp_hold: cycle %0d req/addr got %0h/%08h want 1/00400000", i, bus_req, bus_addr); end
            tick();
        end
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        n_vec++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL bp_accept: got %0h want 0", bus_req); end
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hCAFEF00D;
        tick();
        bus_data_ok = 1'b0;
        n_vec++; if (inst_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL bp_rdata: got %08h want cafef00d", inst_rdata); end
        release_core();
    endtask

    task automatic test_reset_mid();
        longest_stall = 1'b1;
        inst_en       = 1'b1;
        inst_addr     = 32'hBFC00010;
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        n_vec++; if (inst_rdata !== 32'h0) begin n_err++; $display("FAIL rstmid_inst_rdata: got %08h want 0", inst_rdata); end
        n_vec++; if (inst_stall !== 1'b1) begin n_err++; $display("FAIL rstmid_stall_eq_en: got %0h want 1", inst_stall); end
        n_vec++; if (bus_addr !== 32'h0) begin n_err++; $display("FAIL rstmid_bus_addr: got %08h want 0", bus_addr); end
        rst         = 1'b0;
        inst_en     = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hFFFFFFFF;
        tick();
        bus_data_ok = 1'b0;
        n_vec++; if (inst_rdata !== 32'h0) begin n_err++; $display("FAIL rstmid_late_ok: got %08h want 0", inst_rdata); end
        n_vec++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got %0h want 0", bus_req); end
        n_vec++; if (inst_stall !== 1'b0) begin n_err++; $display("FAIL rstmid_stall: got %0h want 0", inst_stall); end
        release_core();
    endtask

    typedef struct {
        logic        is_data;
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } txn_t;

    // Transaction-level reference: at most one transaction in flight, data wins ties,
    // completions are remembered until an edge where the pipeline advances.
    task automatic test_random();
        txn_t        q[$];
        txn_t        t;
        logic        accepted;
        logic        m_i_done;
        logic        m_d_done;
        logic [31:0] m_i_rdata;
        logic [31:0] m_d_rdata;
        logic        i_pend;
        logic        d_pend;
        do_reset();
        accepted  = 1'b0;
        m_i_done  = 1'b0;
        m_d_done  = 1'b0;
        m_i_rdata = 32'h0;
        m_d_rdata = 32'h0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if ($urandom_range(0, 3) == 0) inst_en = ~inst_en;
            if ($urandom_range(0, 3) == 0) data_en = ~data_en;
            inst_addr     = $urandom;
            data_addr     = $urandom;
            data_wdata    = $urandom;
            data_wen      = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            longest_stall = ($urandom_range(0, 9) < 3);
            bus_addr_ok   = $urandom_range(0, 1) == 1;
            bus_data_ok   = $urandom_range(0, 1) == 1;
            bus_rdata     = $urandom;
            #1;
            n_vec++; if (inst_stall !== (inst_en & ~m_i_done)) begin n_err++; $display("FAIL rnd_inst_stall: cycle %0d got %0h want %0h", cyc, inst_stall, inst_en & ~m_i_done); end
            n_vec++; if (data_stall !== (data_en & ~m_d_done)) begin n_err++; $display("FAIL rnd_data_stall: cycle %0d got %0h want %0h", cyc, data_stall, data_en & ~m_d_done); end
            n_vec++; if (inst_rdata !== m_i_rdata) begin n_err++; $display("FAIL rnd_inst_rdata: cycle %0d got %08h want %08h", cyc, inst_rdata, m_i_rdata); end
            n_vec++; if (data_rdata !== m_d_rdata) begin n_err++; $display("FAIL rnd_data_rdata: cycle %0d got %08h want %08h", cyc, data_rdata, m_d_rdata); end
            n_vec++;
            if (q.size() != 0 && !accepted) begin
                if ({bus_req, bus_addr, bus_wr, bus_wstrb, bus_wdata} !== {1'b1, q[0].addr, q[0].wr, q[0].strb, q[0].wdata}) begin
                    n_err++;
                    $display("FAIL rnd_bus_req: cycle %0d got %0h %08h %0h %0h %08h want 1 %08h %0h %0h %08h", cyc,
                             bus_req, bus_addr, bus_wr, bus_wstrb, bus_wdata, q[0].addr, q[0].wr, q[0].strb, q[0].wdata);
                end
            end else if (bus_req !== 1'b0) begin
                n_err++;
                $display("FAIL rnd_bus_idle: cycle %0d got %0h want 0", cyc, bus_req);
            end
            tick();
            i_pend = inst_en & ~m_i_done;
            d_pend = data_en & ~m_d_done;
            if (!longest_stall) begin
                m_i_done = 1'b0;
                m_d_done = 1'b0;
            end
            if (q.size() == 0) begin
                if (d_pend) begin
                    t = '{1'b1, data_addr, data_wen != 4'h0, data_wen, data_wdata};
                    q.push_back(t);
                    accepted = 1'b0;
                end else if (i_pend) begin
                    t = '{1'b0, inst_addr, 1'b0, 4'h0, 32'h0};
                    q.push_back(t);
                    accepted = 1'b0;
                end
            end else if (!accepted) begin
                accepted = bus_addr_ok;
            end else if (bus_data_ok) begin
                t = q.pop_front();
                if (t.is_data) begin
                    m_d_done = 1'b1;
                    if (!t.wr) m_d_rdata = bus_rdata;
                end else begin
                    m_i_done  = 1'b1;
                    m_i_rdata = bus_rdata;
                end
            end
        end
        idle_inputs();
        do_reset();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch();
        test_both();
        test_store();
        test_freeze();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
